// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin merge of FP producer results onto one registered, NaN-boxed writeback port
module fp_wb_arbiter #(
    parameter int NUM_UNITS = 2,
    parameter int FLEN      = 64,
    parameter int ID_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_UNITS-1:0]      unit_done,
    input  logic [NUM_UNITS*ID_W-1:0] unit_id,
    input  logic [NUM_UNITS*FLEN-1:0] unit_rd,
    input  logic [NUM_UNITS-1:0]      unit_single,
    input  logic [NUM_UNITS*5-1:0]    unit_fflags,
    output logic [NUM_UNITS-1:0]      unit_ack,
    output logic                      wb_done,
    output logic [ID_W-1:0]           wb_id,
    output logic [FLEN-1:0]           wb_rd,
    output logic [4:0]                wb_fflags,
    input  logic                      wb_ack,
    input  logic                      fflags_clear,
    output logic [4:0]                fflags_acc
);
    localparam int PW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1;
    localparam logic [FLEN-1:0] BOX = ~FLEN'(32'hFFFF_FFFF);

    logic [PW-1:0]        ptr, gidx, ptr_nxt;
    logic [NUM_UNITS-1:0] grant;
    logic                 found, advance;
    logic [FLEN-1:0]      sel_rd, boxed;

    assign advance  = ~wb_done | wb_ack;
    assign unit_ack = (rst && advance) ? grant : '0;
    assign sel_rd   = unit_rd[gidx*FLEN +: FLEN];
    assign boxed    = unit_single[gidx] ? (sel_rd | BOX) : sel_rd;

    // first requester at or after ptr, wrapping, and the pointer value that follows it
    always_comb begin
        grant   = '0;
        gidx    = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!found && unit_done[(int'(ptr) + k) % NUM_UNITS]) begin
                found = 1'b1;
                gidx  = PW'((int'(ptr) + k) % NUM_UNITS);
            end
        end
        grant[gidx] = found;
        ptr_nxt     = (int'(gidx) == NUM_UNITS - 1) ? '0 : gidx + 1'b1;
    end

    // output stage load, pointer rotation on ack, sticky flags accumulated at retirement
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_done    <= 1'b0;
            wb_id      <= '0;
            wb_rd      <= '0;
            wb_fflags  <= '0;
            ptr        <= '0;
            fflags_acc <= '0;
        end else begin
            if (advance) begin
                wb_done <= found;
                if (found) begin
                    wb_id     <= unit_id[gidx*ID_W +: ID_W];
                    wb_rd     <= boxed;
                    wb_fflags <= unit_fflags[gidx*5 +: 5];
                    ptr       <= ptr_nxt;
                end
            end
            fflags_acc <= fflags_clear ? 5'b0 : (wb_done & wb_ack) ? (fflags_acc | wb_fflags) : fflags_acc;
        end
    end
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed vector table plus fairness sequence for fp_wb_arbiter
module tb_fp_wb_arbiter;
    localparam logic [63:0] R0 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] R1 = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] RS = 64'h1234_5678_3F80_0000;
    localparam logic [63:0] BX = 64'hFFFF_FFFF_3F80_0000;
    localparam logic [63:0] Z  = 64'h0;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   unit_done, unit_single, unit_ack;
    logic [5:0]   unit_id;
    logic [127:0] unit_rd;
    logic [9:0]   unit_fflags;
    logic         wb_done, wb_ack, fflags_clear;
    logic [2:0]   wb_id;
    logic [63:0]  wb_rd;
    logic [4:0]   wb_fflags, fflags_acc;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        rst;
        logic [1:0]  done;
        logic        wack;
        logic        clr;
        logic [1:0]  single;
        logic [63:0] rd1;
        logic [4:0]  ff0;
        logic [4:0]  ff1;
        logic [1:0]  e_ack;
        logic        e_wbd;
        logic [2:0]  e_id;
        logic [63:0] e_rd;
        logic [4:0]  e_acc;
    } vec_t;

    vec_t vq[$];

    fp_wb_arbiter #(.NUM_UNITS(2), .FLEN(64), .ID_W(3)) dut (
        .clk(clk), .rst(rst), .unit_done(unit_done), .unit_id(unit_id),
        .unit_rd(unit_rd), .unit_single(unit_single), .unit_fflags(unit_fflags),
        .unit_ack(unit_ack), .wb_done(wb_done), .wb_id(wb_id), .wb_rd(wb_rd),
        .wb_fflags(wb_fflags), .wb_ack(wb_ack), .fflags_clear(fflags_clear),
        .fflags_acc(fflags_acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s step %0d got=%h want=%h", nm, i, got, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] d, input logic wa, input logic cl,
                       input logic [1:0] s, input logic [63:0] r1, input logic [4:0] f0,
                       input logic [4:0] f1, input logic [1:0] ea, input logic ew,
                       input logic [2:0] ei, input logic [63:0] er, input logic [4:0] ec);
        vq.push_back('{r, d, wa, cl, s, r1, f0, f1, ea, ew, ei, er, ec});
    endtask

    initial begin
        int ep;
        rst = 1'b0; unit_done = '0; unit_single = '0; unit_fflags = '0;
        unit_id = {3'd5, 3'd3}; unit_rd = {R1, R0}; wb_ack = 1'b0; fflags_clear = 1'b0;
        // reset holds acks low and clears state
        add(1'b0, 2'b01, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b0, 3'd0, Z, 5'b0);
        add(1'b0, 2'b11, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b0, 3'd0, Z, 5'b0);
        // first result after release
        add(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b01, 1'b1, 3'd3, R0, 5'b0);
        add(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b0, 3'd0, Z, 5'b0);
        // full throughput, alternating grants
        add(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b10, 1'b1, 3'd5, R1, 5'b0);
        add(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b01, 1'b1, 3'd3, R0, 5'b0);
        add(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b10, 1'b1, 3'd5, R1, 5'b0);
        add(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b01, 1'b1, 3'd3, R0, 5'b0);
        // back-pressure: no acks, output stable
        add(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b1, 3'd3, R0, 5'b0);
        add(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b1, 3'd3, R0, 5'b0);
        add(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b1, 3'd3, R0, 5'b0);
        add(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b10, 1'b1, 3'd5, R1, 5'b0);
        // NaN boxing of a single result with junk upper bits
        add(1'b1, 2'b10, 1'b1, 1'b0, 2'b10, RS, 5'b0, 5'b0, 2'b10, 1'b1, 3'd5, BX, 5'b0);
        // sticky flags accumulate at retirement, not at load
        add(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, R1, 5'b00001, 5'b0, 2'b01, 1'b1, 3'd3, R0, 5'b0);
        add(1'b1, 2'b10, 1'b1, 1'b0, 2'b00, R1, 5'b00001, 5'b10000, 2'b10, 1'b1, 3'd5, R1, 5'b00001);
        add(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b0, 3'd0, Z, 5'b10001);
        add(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, R1, 5'b00100, 5'b0, 2'b01, 1'b1, 3'd3, R0, 5'b10001);
        add(1'b1, 2'b00, 1'b1, 1'b1, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b0, 3'd0, Z, 5'b0);
        // reset mid-operation with ptr=1, then re-arbitration from ptr=0
        add(1'b1, 2'b01, 1'b1, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b01, 1'b1, 3'd3, R0, 5'b0);
        add(1'b0, 2'b11, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b00, 1'b0, 3'd0, Z, 5'b0);
        add(1'b1, 2'b11, 1'b0, 1'b0, 2'b00, R1, 5'b0, 5'b0, 2'b01, 1'b1, 3'd3, R0, 5'b0);
        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; unit_done = vq[i].done; wb_ack = vq[i].wack;
            fflags_clear = vq[i].clr; unit_single = vq[i].single;
            unit_rd = {vq[i].rd1, R0}; unit_fflags = {vq[i].ff1, vq[i].ff0};
            #1;
            chk("unit_ack", i, 64'(unit_ack), 64'(vq[i].e_ack));
            @(posedge clk);
            #1;
            chk("wb_done", i, 64'(wb_done), 64'(vq[i].e_wbd));
            chk("fflags_acc", i, 64'(fflags_acc), 64'(vq[i].e_acc));
            if (vq[i].e_wbd) begin
                chk("wb_id", i, 64'(wb_id), 64'(vq[i].e_id));
                chk("wb_rd", i, wb_rd, vq[i].e_rd);
            end
        end
        // fairness: both units requesting continuously, grants rotate from ptr=1
        ep = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            unit_done = 2'b11; wb_ack = 1'b1; fflags_clear = 1'b0; unit_single = 2'b00;
            #1;
            chk("rr_ack", c, 64'(unit_ack), 64'(2'b01 << ep));
            @(posedge clk);
            #1;
            chk("rr_id", c, 64'(wb_id), (ep == 1) ? 64'd5 : 64'd3);
            chk("rr_done", c, 64'(wb_done), 64'd1);
            ep = 1 - ep;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Collects results from the FPU's intermediate writeback producers (the fused multiply-add path, the standalone multiply path, and any later FP units) and merges them onto the single FP writeback port. Arbitration is round-robin, and each producer gets an ack handshake. The block NaN-boxes single-precision results and registers the selected result for one cycle. It also keeps a sticky OR of all retired exception flags for the fcsr update logic.

## Interface
Parameters:
- NUM_UNITS, 2, number of intermediate-writeback producers; index 0 is the FMA/add path, index 1 is the multiply path.
- FLEN, 64, result data width.
- ID_W, 3, instruction id width (matches id_t).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- unit_done  in  NUM_UNITS  producer i has a result pending; held until acked.
- unit_id  in  NUM_UNITS×ID_W  id of each pending result.
- unit_rd  in  NUM_UNITS×FLEN  result data.
- unit_single  in  NUM_UNITS  result is single precision; only bits [31:0] of unit_rd are meaningful.
- unit_fflags  in  NUM_UNITS×5  exception flags {NV,DZ,OF,UF,NX}.
- unit_ack  out  NUM_UNITS  one-hot or zero; result i is consumed this cycle.
- wb_done  out  1  registered result valid.
- wb_id  out  ID_W  registered id.
- wb_rd  out  FLEN  registered, NaN-boxed data.
- wb_fflags  out  5  registered flags.
- wb_ack  in  1  downstream consumes the wb_* result this cycle.
- fflags_clear  in  1  clears the sticky accumulator.
- fflags_acc  out  5  sticky OR of fflags of every retired result.

## Operation
- Output stage:
  - It holds one result: wb_done plus its payload.
  - advance = ~wb_done | wb_ack.
  - The stage loads on advance and holds otherwise.
- Arbitration:
  - The requests are the unit_done lines.
  - A priority pointer ptr (log2 NUM_UNITS bits) gives highest priority to unit ptr, then ptr+1, and so on, wrapping modulo NUM_UNITS.
  - grant is the first requester in that order; it is purely combinational from unit_done and ptr.
- Acknowledge:
  - unit_ack[i] = grant[i] & advance.
  - Exactly one ack is raised per load, and none when there is no request or no advance.
- Pointer update: on any ack to unit g, ptr becomes (g+1) mod NUM_UNITS. Otherwise ptr holds.
- Load:
  - On advance, wb_done is set to |unit_done.
  - When a grant exists, the payload comes from the granted unit.
  - When no grant exists, the payload registers are don't-care but must not change fflags_acc.
- NaN boxing:
  - If unit_single[g] is 1, wb_rd = {(FLEN-32) ones, unit_rd[g][31:0]}.
  - Otherwise wb_rd = unit_rd[g].
  - No other data modification is made.
- Sticky flags:
  - On a cycle with wb_done & wb_ack, fflags_acc |= wb_fflags, i.e. accumulation happens at retirement, not at load.
  - fflags_clear has priority over retirement. If both occur in the same cycle, fflags_acc becomes 0 and the retiring flags are dropped; the fcsr write path owns that ordering.
- Input rule: a producer must not change id, rd, single or fflags while done is high and ack is low. The block does not check this.

## Timing
- Reset (rst=0 at a clock edge): wb_done=0, ptr=0, fflags_acc=0; wb_id, wb_rd and wb_fflags are 0.
- While rst=0, unit_ack is 0 regardless of unit_done.
- Latency: unit_done is acked in cycle N and wb_done=1 with that payload in cycle N+1. There is no combinational path from unit_* to wb_*.
- Throughput: one result per cycle when wb_ack is held high.
- Back-pressure:
  - With wb_done=1 and wb_ack=0, all unit_ack are 0 and the wb_* outputs are stable.
  - A simultaneous wb_ack and a new grant retire the old result and load the new one in the same edge, with no bubble.
- Fairness: with all units continuously requesting, grants rotate 0,1,…,NUM_UNITS-1,0. Any requester waits at most NUM_UNITS-1 loads.
- Reset mid-operation: any in-flight registered result is discarded, and producers still holding done are re-arbitrated from ptr=0 after reset releases.

## Test plan
- Reset → wb_done=0, fflags_acc=0, unit_ack=0 while rst=0. After release with unit_done=2'b01, id=3, rd=64'h4000_0000_0000_0000 → ack[0] that cycle, then wb_done=1, wb_id=3, same rd next cycle.
- Both units request continuously with wb_ack=1 → ack sequence 0,1,0,1; wb_id alternates between the two ids, one result per cycle.
- wb_ack=0 for 3 cycles with both requesting → no acks, wb_* stable. wb_ack=1 → old result retired and new one loaded the same edge.
- Unit 1 single result rd[31:0]=32'h3F80_0000, unit_single=1 → wb_rd=64'hFFFF_FFFF_3F80_0000.
- Retire results carrying fflags 5'b00001 then 5'b10000 → fflags_acc=5'b10001. fflags_clear on the same cycle as a retirement of 5'b00100 → fflags_acc=0.
- Assert rst=0 while wb_done=1 → wb_done=0, ptr=0 next cycle. A unit still holding done is acked in the first cycle after release.
